// File: rtl/pipe_pkg.sv
// Shared types and helpers for the valid/ready pipeline stage chain.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pipe_pkg;

    // Per-slot occupancy. The encoding 2'd3 is never produced and is recovered as EMPTY.
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_BUSY  = 2'd1,
        SLOT_FULL  = 2'd2
    } slot_state_t;

    // Width of a counter able to hold 0..2*stages beats.
    function automatic int count_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid/ready stage: main register M plus skid register S, with a registered ready.
// Latency: 1 cycle from input transfer to out_data when the slot was empty or draining.
// Backpressure: absorbs one extra beat in S; in_ready drops only when both M and S hold data.
// Optional flush port enabled by `define PIPE_STAGE_FLUSH_EN.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
`ifdef PIPE_STAGE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    slot_state_t      state;
    slot_state_t      state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    // State register; illegal encodings fall back to EMPTY through the next-state logic.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: occupancy moves by +1 on input-only, -1 on output-only transfers.
    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_BUSY: begin
                if (in_xfer && !out_xfer) begin
                    state_nxt = SLOT_FULL;
                end else if (!in_xfer && out_xfer) begin
                    state_nxt = SLOT_EMPTY;
                end else begin
                    state_nxt = SLOT_BUSY;
                end
            end
            SLOT_FULL: begin
                state_nxt = out_xfer ? SLOT_BUSY : SLOT_FULL;
            end
            default: begin
                state_nxt = in_xfer ? SLOT_BUSY : SLOT_EMPTY;
            end
        endcase
`ifdef PIPE_STAGE_FLUSH_EN
        if (flush) begin
            state_nxt = SLOT_EMPTY;
        end
`endif
    end

    // Outputs and register load enables, decoded from state only so ready stays registered.
    always_comb begin
        in_ready       = (state != SLOT_FULL);
        out_valid      = (state == SLOT_BUSY) || (state == SLOT_FULL);
        in_xfer        = in_valid && in_ready;
        out_xfer       = out_valid && out_ready;
        load_main_in   = in_xfer && ((state != SLOT_BUSY) || out_xfer);
        load_skid      = in_xfer && (state == SLOT_BUSY) && !out_xfer;
        load_main_skid = (state == SLOT_FULL) && out_xfer;
`ifdef PIPE_STAGE_FLUSH_EN
        // A flushed beat must never be captured; data registers simply hold.
        if (flush) begin
            load_main_in   = 1'b0;
            load_skid      = 1'b0;
            load_main_skid = 1'b0;
        end
`endif
    end

    // Payload registers: hold whenever nothing loads them, so out_data never glitches.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign out_data = main_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of STAGES skid-buffered valid/ready stages with an occupancy counter.
// Latency: beat accepted at edge n is on out_data_o after edge n+STAGES-1; 1 beat/cycle sustained.
// Backpressure: holds up to 2*STAGES beats, then in_ready_o drops; flush via `define PIPE_STAGE_FLUSH_EN.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_n,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [WIDTH-1:0]                   in_data_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [WIDTH-1:0]                   out_data_o,
`ifdef PIPE_STAGE_FLUSH_EN
    input  logic                               flush_i,
`endif
    output logic [$clog2(2*STAGES+1)-1:0]      count_o
);

    localparam int            CW      = count_width(STAGES);
    localparam logic [CW-1:0] CNT_MAX = CW'(2 * STAGES);

    // Index k is the input side of stage k; index STAGES is the chain output.
    logic             vld [STAGES+1];
    logic             rdy [STAGES+1];
    logic [WIDTH-1:0] dat [STAGES+1];
    logic [CW-1:0]    count_q;
    logic             in_xfer;
    logic             out_xfer;

    assign vld[0]      = in_valid_i;
    assign dat[0]      = in_data_i;
    assign in_ready_o  = rdy[0];
    assign out_valid_o = vld[STAGES];
    assign out_data_o  = dat[STAGES];
    assign rdy[STAGES] = out_ready_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_skid_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk_i    (clk_i),
            .rst_n    (rst_n),
`ifdef PIPE_STAGE_FLUSH_EN
            .flush    (flush_i),
`endif
            .in_valid (vld[k]),
            .in_ready (rdy[k]),
            .in_data  (dat[k]),
            .out_valid(vld[k+1]),
            .out_ready(rdy[k+1]),
            .out_data (dat[k+1])
        );
    end

    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;

    // Occupancy: +1 per accepted beat, -1 per delivered beat, clamped to 0..2*STAGES.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
`ifdef PIPE_STAGE_FLUSH_EN
        end else if (flush_i) begin
            count_q <= '0;
`endif
        end else if (in_xfer && !out_xfer && (count_q != CNT_MAX)) begin
            count_q <= count_q + CW'(1);
        end else if (out_xfer && !in_xfer && (count_q != '0)) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (WIDTH=32, STAGES=3).
// Scoreboard queue is fed on accepted inputs and drained on delivered outputs at each negedge.
// Optional flush scenario is compiled in when PIPE_STAGE_FLUSH_EN is defined.
module tb_pipe_stage_chain;

    localparam int WIDTH  = 32;
    localparam int STAGES = 3;
    localparam int CAP    = 2 * STAGES;
    localparam int CW     = $clog2(2 * STAGES + 1);

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_data_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [WIDTH-1:0] out_data_o;
    logic [CW-1:0]    count_o;
`ifdef PIPE_STAGE_FLUSH_EN
    logic             flush_i = 1'b0;
`endif

    pipe_stage_chain #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
`ifdef PIPE_STAGE_FLUSH_EN
        .flush_i    (flush_i),
`endif
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    int               checks   = 0;
    int               failures = 0;
    logic [WIDTH-1:0] sb_q[$];
    bit               mon_en = 1'b0;

    typedef struct {
        int          n_push;
        logic [31:0] base;
        int          exp_count;
        logic        exp_in_ready;
    } bp_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        while (((count_o != '0) || (sb_q.size() != 0)) && (n < 8 * CAP + 20)) begin
            cycle();
            n++;
        end
        check({name, "_count_drained"}, 64'(count_o), 64'(0));
        check({name, "_model_drained"}, 64'(sb_q.size()), 64'(0));
    endtask

    // Scoreboard monitor: compare occupancy, retire delivered beats, record accepted beats.
    always @(negedge clk_i) begin
        logic [WIDTH-1:0] exp_d;
        bit               flushing;
        flushing = 1'b0;
`ifdef PIPE_STAGE_FLUSH_EN
        flushing = flush_i;
`endif
        if (!rst_n) begin
            sb_q.delete();
        end else if (mon_en) begin
            check("count_vs_model", 64'(count_o), 64'(sb_q.size()));
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none t=%0t", out_data_o, $time);
                end else begin
                    exp_d = sb_q.pop_front();
                    check("out_data_order", 64'(out_data_o), 64'(exp_d));
                end
            end
            if (flushing) begin
                sb_q.delete();
            end else if (in_valid_i && in_ready_o) begin
                sb_q.push_back(in_data_i);
            end
        end
    end

    // Global time bound so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bp_vec_t vecs[5];
        int      sent;
        int      cyc;
        int      n;

        vecs[0] = '{n_push: 2, base: 32'hA0, exp_count: 2, exp_in_ready: 1'b1};
        vecs[1] = '{n_push: 6, base: 32'hB0, exp_count: 6, exp_in_ready: 1'b0};
        vecs[2] = '{n_push: 9, base: 32'hC0, exp_count: 6, exp_in_ready: 1'b0};
        vecs[3] = '{n_push: 5, base: 32'hD0, exp_count: 5, exp_in_ready: 1'b1};
        vecs[4] = '{n_push: 1, base: 32'hE0, exp_count: 1, exp_in_ready: 1'b1};

        void'($urandom(32'd20240611));

        // Reset held with valid input present.
        in_valid_i = 1'b1;
        in_data_i  = 32'h55;
        repeat (3) cycle();
        check("rst_out_valid", 64'(out_valid_o), 64'(0));
        check("rst_count", 64'(count_o), 64'(0));
        check("rst_in_ready", 64'(in_ready_o), 64'(1));
        check("rst_out_data", 64'(out_data_o), 64'(0));
        in_valid_i = 1'b0;
        rst_n      = 1'b1;
        mon_en     = 1'b1;
        cycle();

        // Streaming with no backpressure: fixed latency and steady occupancy.
        out_ready_i = 1'b1;
        for (int i = 1; i <= 16 + STAGES; i++) begin
            if (i - STAGES >= 1) begin
                check("stream_out_valid", 64'(out_valid_o), 64'(1));
                check("stream_out_data", 64'(out_data_o), 64'(i - STAGES));
            end
            if ((i - 1 >= STAGES) && (i - 1 <= 16)) begin
                check("stream_count", 64'(count_o), 64'(STAGES));
            end
            if (i <= 16) begin
                check("stream_in_ready", 64'(in_ready_o), 64'(1));
            end
            in_valid_i = (i <= 16);
            in_data_i  = 32'(i);
            cycle();
        end
        drain("stream");

        // Backpressure table: fill with output stalled, check level, then release and drain.
        for (int v = 0; v < 5; v++) begin
            out_ready_i = 1'b0;
            for (int k = 0; k < vecs[v].n_push; k++) begin
                in_valid_i = 1'b1;
                in_data_i  = vecs[v].base + 32'(k);
                cycle();
            end
            in_valid_i = 1'b0;
            check("bp_count", 64'(count_o), 64'(vecs[v].exp_count));
            check("bp_in_ready", 64'(in_ready_o), 64'(vecs[v].exp_in_ready));
            out_ready_i = 1'b1;
            if (!vecs[v].exp_in_ready) begin
                n = 0;
                while (!in_ready_o && (n < STAGES + 1)) begin
                    cycle();
                    n++;
                end
                check("bp_release_in_ready", 64'(in_ready_o), 64'(1));
            end
            drain("bp");
        end

        // Reset asserted with beats in flight: outputs return to reset values at once.
        out_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'h11 + 32'(k);
            cycle();
        end
        in_valid_i = 1'b0;
        check("midrst_pre_count", 64'(count_o), 64'(3));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid_o), 64'(0));
        check("midrst_count", 64'(count_o), 64'(0));
        check("midrst_in_ready", 64'(in_ready_o), 64'(1));
        check("midrst_out_data", 64'(out_data_o), 64'(0));
        cycle();
        rst_n = 1'b1;
        cycle();

`ifdef PIPE_STAGE_FLUSH_EN
        // Flush with a competing input beat: the input is dropped, chain empties.
        out_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'h31 + 32'(k);
            cycle();
        end
        check("flush_pre_count", 64'(count_o), 64'(3));
        flush_i     = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hDEAD;
        out_ready_i = 1'b1;
        cycle();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("flush_out_valid", 64'(out_valid_o), 64'(0));
        check("flush_count", 64'(count_o), 64'(0));
        check("flush_in_ready", 64'(in_ready_o), 64'(1));
        in_valid_i = 1'b1;
        in_data_i  = 32'hBEEF;
        cycle();
        in_valid_i = 1'b0;
        n = 0;
        while (!out_valid_o && (n < 4 * STAGES)) begin
            cycle();
            n++;
        end
        check("flush_next_data", 64'(out_data_o), 64'(32'hBEEF));
        drain("flush");
`endif

        // Alternate completely full and completely empty.
        for (int r = 0; r < 20; r++) begin
            out_ready_i = 1'b0;
            for (int k = 0; k < CAP; k++) begin
                in_valid_i = 1'b1;
                in_data_i  = 32'(r * 16 + k);
                cycle();
            end
            in_valid_i = 1'b0;
            check("alt_full_count", 64'(count_o), 64'(CAP));
            check("alt_full_in_ready", 64'(in_ready_o), 64'(0));
            drain("alt");
        end

        // Random valid/ready toggling against the scoreboard.
        sent = 0;
        cyc  = 0;
        while ((sent < 10000) && (cyc < 60000)) begin
            in_valid_i  = 1'($urandom_range(0, 1));
            in_data_i   = $urandom;
            out_ready_i = 1'($urandom_range(0, 1));
            if (in_valid_i && in_ready_o) begin
                sent++;
            end
            cycle();
            cyc++;
        end
        check("rand_beats_sent", 64'(sent), 64'(10000));
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
